// File: rtl/vga_timing_gen_pkg.sv
// Shared raster-timing definitions for the VGA timing generator and the
// overlay renderers that consume its scan position.
//   - 640x480@60 timing constants and derived line/frame totals
//   - counter and divider widths
//   - sync_bus_t: the {hsync, vsync, video_on} bundle carried by the delay line
//   - small decode helpers shared by the generator and renderers
package vga_timing_gen_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int CNT_W = 10;  // covers totals up to 1024
  localparam int DIV_W = 4;   // covers CLK_DIV up to 16

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_bus_t;

  // True when lo <= v < hi. Compared as int so a window end of 1024 still works.
  function automatic logic in_span(cnt_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  // Drive a sync line to its active level when inside the sync window.
  function automatic logic sync_level(logic active, logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-length shift register that delays a small bus by DEPTH clk cycles.
//   clk   in  1      system clock
//   rst   in  1      synchronous active-high clear; all stages load RST_VAL
//   din   in  WIDTH  bus to delay
//   dout  out WIDTH  din delayed by DEPTH cycles (a plain wire when DEPTH=0)
module sync_delay_line
  import vga_timing_gen_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_passthru
    // No storage: clock and reset are intentionally left unused.
    logic unused_s;
    assign unused_s = clk ^ rst;
    assign dout     = din;
  end else begin : g_stages
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Clearing every stage on reset keeps a half-shifted sync pulse from
    // reaching the pins after a mid-frame reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: pixel strobe, scan counters, sync/blank decode and
// a pipeline-aligned copy of sync/blank for the VGA pins.
//   clk          in  1   system clock
//   rst          in  1   synchronous active-high reset
//   counter_x    out 10  pixel column 0..H_TOTAL-1
//   counter_y    out 10  line 0..V_TOTAL-1
//   pixel_tick   out 1   counters advance on the edge where this is high
//   video_on     out 1   inside the visible area
//   hsync/vsync  out 1   sync aligned with the counters
//   line_start   out 1   first clk of x==0 on every line
//   frame_start  out 1   first clk of (0,0) after a vertical wrap
//   hsync_d/vsync_d/video_on_d out 1  same signals delayed PIPE_DELAY clk
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] counter_x,
  output logic [CNT_W-1:0] counter_y,
  output logic             pixel_tick,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync_d,
  output logic             vsync_d,
  output logic             video_on_d
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam cnt_t             X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam cnt_t             Y_LAST   = CNT_W'(V_TOTAL - 1);

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (CLK_DIV < 1) || (CLK_DIV > 16) ||
      (PIPE_DELAY < 0)) begin : g_bad_params
    $error("vga_timing_gen: timing parameters out of range");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  cnt_t             x_q, x_d;
  cnt_t             y_q, y_d;
  logic             von_q, von_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;

  // Next-state: divider, counters, and decode of the *next* counter values so
  // the decoded outputs switch on the same edge as the counters.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;

    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + 4'd1;
    end
    tick_d = (div_d == DIV_LAST);

    if (tick_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d = '0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    von_d = in_span(x_d, 0, H_VISIBLE) && in_span(y_d, 0, V_VISIBLE);
    hs_d  = sync_level(in_span(x_d, HS_START, HS_END), SYNC_POL);
    vs_d  = sync_level(in_span(y_d, VS_START, VS_END), SYNC_POL);
    // Pulses only on an advancing edge, so the post-reset (0,0) is silent.
    ls_d  = tick_q && (x_d == '0);
    fs_d  = ls_d && (y_d == '0);
  end

  // State registers with synchronous reset; reset wins regardless of divider phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      von_q  <= 1'b0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
      von_q  <= von_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign counter_x   = x_q;
  assign counter_y   = y_q;
  assign pixel_tick  = tick_q;
  assign video_on    = von_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  sync_bus_t dly_in;
  sync_bus_t dly_out;

  assign dly_in.hsync    = hs_q;
  assign dly_in.vsync    = vs_q;
  assign dly_in.video_on = von_q;

  sync_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_DELAY),
    .RST_VAL({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .din (dly_in),
    .dout(dly_out)
  );

  assign hsync_d    = dly_out.hsync;
  assign vsync_d    = dly_out.vsync;
  assign video_on_d = dly_out.video_on;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic tick, von, hs, vs, ls, fs, hsd, vsd, vond;
  } obs_t;

  typedef struct {
    int d, hv, hf, hs, hb, vv, vf, vs, vb, pd;
    bit pol;
  } geo_t;

  typedef struct {
    int k;
    int x, y, hs, ls, von;
  } vec_t;

  // instance a: default 640x480, CLK_DIV=4, PIPE_DELAY=2
  logic [9:0] a_x, a_y;
  logic a_tick, a_von, a_hs, a_vs, a_ls, a_fs, a_hsd, a_vsd, a_vond;
  // instance b: default geometry, CLK_DIV=1, PIPE_DELAY=0
  logic [9:0] b_x, b_y;
  logic b_tick, b_von, b_hs, b_vs, b_ls, b_fs, b_hsd, b_vsd, b_vond;
  // instance c: tiny geometry so whole frames fit, active-high sync
  logic [9:0] c_x, c_y;
  logic c_tick, c_von, c_hs, c_vs, c_ls, c_fs, c_hsd, c_vsd, c_vond;

  obs_t a_obs, b_obs, c_obs;
  assign a_obs = {a_x, a_y, a_tick, a_von, a_hs, a_vs, a_ls, a_fs, a_hsd, a_vsd, a_vond};
  assign b_obs = {b_x, b_y, b_tick, b_von, b_hs, b_vs, b_ls, b_fs, b_hsd, b_vsd, b_vond};
  assign c_obs = {c_x, c_y, c_tick, c_von, c_hs, c_vs, c_ls, c_fs, c_hsd, c_vsd, c_vond};

  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .counter_x(a_x), .counter_y(a_y), .pixel_tick(a_tick),
    .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs),
    .hsync_d(a_hsd), .vsync_d(a_vsd), .video_on_d(a_vond));

  vga_timing_gen #(.CLK_DIV(1), .PIPE_DELAY(0)) u_b (
    .clk(clk), .rst(rst), .counter_x(b_x), .counter_y(b_y), .pixel_tick(b_tick),
    .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs),
    .hsync_d(b_hsd), .vsync_d(b_vsd), .video_on_d(b_vond));

  vga_timing_gen #(.CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                   .SYNC_POL(1'b1), .PIPE_DELAY(3)) u_c (
    .clk(clk), .rst(rst), .counter_x(c_x), .counter_y(c_y), .pixel_tick(c_tick),
    .video_on(c_von), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs),
    .hsync_d(c_hsd), .vsync_d(c_vsd), .video_on_d(c_vond));

  int   n_checks = 0;
  int   n_err    = 0;
  int   kk       = 0;   // clk edges since rst was last sampled high (0 = reset edge)
  geo_t ga, gb, gc;

  // frame statistics for instance c
  bit c_seen    = 1'b0;
  int c_last_fs = 0;
  int c_von_cnt = 0;

  // Pixel ticks consumed after k edges: the strobe is registered, so the
  // first advance happens one edge after the first strobe.
  function automatic int ticks(int k, int d);
    if (k <= 0) return 0;
    if (d == 1) return k - 1;
    return k / d;
  endfunction

  function automatic obs_t base(int k, geo_t g);
    obs_t o;
    int ht, vt, p, pp, x, y;
    o = '0;
    o.hs = !g.pol;
    o.vs = !g.pol;
    if (k <= 0) return o;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    p  = ticks(k, g.d);
    pp = ticks(k - 1, g.d);
    x  = p % ht;
    y  = (p / ht) % vt;
    o.x    = 10'(x);
    o.y    = 10'(y);
    o.tick = ((k % g.d) == (g.d - 1));
    o.von  = (x < g.hv) && (y < g.vv);
    o.hs   = (x >= g.hv + g.hf && x < g.hv + g.hf + g.hs) ? g.pol : !g.pol;
    o.vs   = (y >= g.vv + g.vf && y < g.vv + g.vf + g.vs) ? g.pol : !g.pol;
    o.ls   = (p != pp) && (x == 0);
    o.fs   = o.ls && (y == 0);
    return o;
  endfunction

  function automatic obs_t model(int k, geo_t g);
    obs_t o, dl;
    o      = base(k, g);
    dl     = base(k - g.pd, g);
    o.hsd  = dl.hs;
    o.vsd  = dl.vs;
    o.vond = dl.von;
    return o;
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got x=%0d y=%0d flags=%b want x=%0d y=%0d flags=%b",
               name, kk, act.x, act.y, act[8:0], exp.x, exp.y, exp[8:0]);
    end
  endtask

  task automatic check_val(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s k=%0d got %0d want %0d", name, kk, act, exp);
    end
  endtask

  // One clk edge, then compare all instances against the model.
  task automatic step();
    @(posedge clk);
    if (rst) kk = 0;
    else     kk = kk + 1;
    #1;
    check_obs("scan_a", a_obs, model(kk, ga));
    check_obs("scan_b", b_obs, model(kk, gb));
    check_obs("scan_c", c_obs, model(kk, gc));
    if (rst) begin
      c_seen    = 1'b0;
      c_von_cnt = 0;
    end else begin
      if (c_fs === 1'b1) begin
        if (c_seen) begin
          check_val("frame_period_c", kk - c_last_fs, 15 * 9 * 3);
          check_val("visible_ticks_c", c_von_cnt, 8 * 4);
        end
        c_seen    = 1'b1;
        c_last_fs = kk;
        c_von_cnt = 0;
      end
      if (c_von === 1'b1 && c_tick === 1'b1) c_von_cnt++;
    end
  endtask

  vec_t vecs[12];

  initial begin
    ga = '{d:4, hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, pd:2, pol:1'b0};
    gb = '{d:1, hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33, pd:0, pol:1'b0};
    gc = '{d:3, hv:8, hf:2, hs:3, hb:2, vv:4, vf:1, vs:2, vb:2, pd:3, pol:1'b1};

    // {k, x, y, hsync, line_start, video_on} for instance a
    vecs[0]  = '{k:1,    x:0,   y:0, hs:1, ls:0, von:1};
    vecs[1]  = '{k:4,    x:1,   y:0, hs:1, ls:0, von:1};
    vecs[2]  = '{k:2559, x:639, y:0, hs:1, ls:0, von:1};
    vecs[3]  = '{k:2560, x:640, y:0, hs:1, ls:0, von:0};
    vecs[4]  = '{k:2623, x:655, y:0, hs:1, ls:0, von:0};
    vecs[5]  = '{k:2624, x:656, y:0, hs:0, ls:0, von:0};
    vecs[6]  = '{k:3007, x:751, y:0, hs:0, ls:0, von:0};
    vecs[7]  = '{k:3008, x:752, y:0, hs:1, ls:0, von:0};
    vecs[8]  = '{k:3199, x:799, y:0, hs:1, ls:0, von:0};
    vecs[9]  = '{k:3200, x:0,   y:1, hs:1, ls:1, von:1};
    vecs[10] = '{k:3201, x:0,   y:1, hs:1, ls:0, von:1};
    vecs[11] = '{k:3204, x:1,   y:1, hs:1, ls:0, von:1};

    // reset state
    rst = 1'b1;
    repeat (3) step();
    check_val("reset_x", int'(a_x), 0);
    check_val("reset_von", int'(a_von), 0);
    check_val("reset_hsync_d", int'(a_hsd), 1);
    check_val("reset_tick", int'(a_tick), 0);
    rst = 1'b0;

    // table-driven checks on the default instance
    for (int i = 0; i < 12; i++) begin
      while (kk < vecs[i].k) step();
      check_val("tbl_x", int'(a_x), vecs[i].x);
      check_val("tbl_y", int'(a_y), vecs[i].y);
      check_val("tbl_hsync", int'(a_hs), vecs[i].hs);
      check_val("tbl_line_start", int'(a_ls), vecs[i].ls);
      check_val("tbl_video_on", int'(a_von), vecs[i].von);
    end

    // fast instance: 800 clk per line
    rst = 1'b1;
    step();
    rst = 1'b0;
    while (kk < 801) step();
    check_val("fast_wrap_x", int'(b_x), 0);
    check_val("fast_wrap_y", int'(b_y), 1);
    check_val("fast_line_start", int'(b_ls), 1);

    // reset mid-hsync (x=700, divider phase 2): delay line must flush
    while (kk < 2802) step();
    check_val("pre_rst_x", int'(a_x), 700);
    check_val("pre_rst_hsync", int'(a_hs), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("midrst_x", int'(a_x), 0);
    check_val("midrst_y", int'(a_y), 0);
    check_val("midrst_von", int'(a_von), 0);
    check_val("midrst_hsync_d", int'(a_hsd), 1);
    step();
    check_val("post_rst_hsync_d", int'(a_hsd), 1);
    check_val("post_rst_von", int'(a_von), 1);
    step();
    check_val("post_rst_von_d_k2", int'(a_vond), 0);
    step();
    check_val("post_rst_von_d_k3", int'(a_vond), 1);

    // randomized run lengths and reset phases
    for (int r = 0; r < 12; r++) begin
      int len;
      int rlen;
      len  = int'($urandom_range(50, 4000));
      rlen = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) step();
      rst = 1'b1;
      for (int i = 0; i < rlen; i++) step();
      rst = 1'b0;
    end
    for (int i = 0; i < 1500; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
